// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: types, constants and helpers shared by the L2 Spandex request arbiter.
//   cpu_msg_t, hsize_t, hprot_t, addr_t, word_t, amo_t, dcs_t, cache_id_t, line_t
//   l2_req_pkt_t    : one CPU request packet toward the L2
//   AMO_NONE        : amo encoding for "not an atomic memory op"
//   expects_rd_rsp  : true when the L2 will answer the request with a read line
package l2_arb_pkg;
  typedef enum logic [1:0] {CPU_READ, CPU_READ_ATOM, CPU_WRITE, CPU_WRITE_ATOM} cpu_msg_t;
  typedef logic [2:0]   hsize_t;
  typedef logic [1:0]   hprot_t;
  typedef logic [31:0]  addr_t;
  typedef logic [63:0]  word_t;
  typedef logic [5:0]   amo_t;
  typedef logic [1:0]   dcs_t;
  typedef logic [3:0]   cache_id_t;
  typedef logic [127:0] line_t;
  localparam amo_t AMO_NONE = '0;
  typedef struct packed {
    cpu_msg_t  cpu_msg;
    hsize_t    hsize;
    hprot_t    hprot;
    addr_t     addr;
    word_t     word;
    amo_t      amo;
    logic      aq;
    logic      rl;
    logic      dcs_en;
    logic      use_owner_pred;
    dcs_t      dcs;
    cache_id_t pred_cid;
  } l2_req_pkt_t;
  function automatic logic expects_rd_rsp(input cpu_msg_t cpu_msg, input amo_t amo);
    return cpu_msg == CPU_READ || cpu_msg == CPU_READ_ATOM || amo != AMO_NONE;
  endfunction
endpackage

// File: rtl/l2_spandex_req_arbiter_owner_fifo.sv
// l2_arb_owner_fifo: in-order FIFO of requester IDs owning outstanding reads.
//   clk, rst (sync, active-low) | push, din : enqueue an ID (ignored when full)
//   pop : dequeue head (ignored when empty) | full, empty, head : status and oldest ID
module l2_arb_owner_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  // a full FIFO refuses a push even if a pop frees a slot in the same cycle
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/l2_spandex_req_arbiter.sv
// l2_spandex_req_arbiter: round-robin share of the L2 Spandex CPU request port among N_REQ requesters.
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_data            : per-requester request handshakes
//   l2_cpu_req_valid/ready/data             : registered request toward the L2
//   l2_rd_rsp_valid/ready/data_line         : read response from the L2
//   rsp_valid/rsp_ready/rsp_line            : response routed to the owning requester
//   orphan_rsp_err                          : sticky, response seen with no read outstanding
//   Optional macro L2_ARB_ATOMIC_LOCK_EN: lock arbitration to a requester between its
//   CPU_READ_ATOM and CPU_WRITE_ATOM.
module l2_spandex_req_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int OUTST_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  l2_req_pkt_t       req_data [N_REQ],
  output logic              l2_cpu_req_valid,
  input  logic              l2_cpu_req_ready,
  output l2_req_pkt_t       l2_cpu_req_data,
  input  logic              l2_rd_rsp_valid,
  output logic              l2_rd_rsp_ready,
  input  line_t             l2_rd_rsp_data_line,
  output logic [N_REQ-1:0]  rsp_valid,
  input  logic [N_REQ-1:0]  rsp_ready,
  output line_t             rsp_line,
  output logic              orphan_rsp_err
);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] expects, elig, locked_out, grant;
  logic [IW-1:0] rr_ptr, gidx, head;
  logic found, accept, push, pop, fifo_full, fifo_empty, out_full;
  l2_req_pkt_t out_pkt;
  always_comb begin
    expects = '0;
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      expects[i] = expects_rd_rsp(req_data[i].cpu_msg, req_data[i].amo);
      elig[i] = req_valid[i] & ~(expects[i] & fifo_full) & ~locked_out[i];
    end
  end
  // first eligible requester at or after rr_ptr, in circular order
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && elig[(int'(rr_ptr) + k) % N_REQ]) begin
        found = 1'b1;
        gidx = IW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
    grant = found ? (N_REQ'(1) << gidx) : '0;
  end
  assign accept = rst & found & (~out_full | l2_cpu_req_ready);
  assign req_ready = accept ? grant : '0;
  assign push = accept & expects[gidx];
  assign l2_cpu_req_valid = out_full;
  assign l2_cpu_req_data = out_pkt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_full <= 1'b0;
      out_pkt <= '0;
      rr_ptr <= '0;
      orphan_rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        out_full <= 1'b1;
        out_pkt <= req_data[gidx];
        rr_ptr <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
      end else if (l2_cpu_req_ready) begin
        out_full <= 1'b0;
      end
      if (l2_rd_rsp_valid && fifo_empty) orphan_rsp_err <= 1'b1;
    end
  end
  // responses with nothing outstanding are swallowed so the L2 never stalls on them
  assign rsp_valid = (rst & l2_rd_rsp_valid & ~fifo_empty) ? (N_REQ'(1) << head) : '0;
  assign l2_rd_rsp_ready = rst & l2_rd_rsp_valid & (fifo_empty | rsp_ready[head]);
  assign pop = rst & l2_rd_rsp_valid & ~fifo_empty & rsp_ready[head];
  assign rsp_line = l2_rd_rsp_data_line;
  l2_arb_owner_fifo #(.DEPTH(OUTST_DEPTH), .W(IW)) u_owner_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(gidx),
    .pop(pop),
    .full(fifo_full),
    .empty(fifo_empty),
    .head(head)
  );
`ifdef L2_ARB_ATOMIC_LOCK_EN
  logic lock_valid;
  logic [IW-1:0] lock_id;
  always_comb begin
    locked_out = '0;
    for (int i = 0; i < N_REQ; i++) locked_out[i] = lock_valid & (lock_id != IW'(i));
  end
  // only the lock owner can be accepted while locked, so any accepted WRITE_ATOM releases it
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_valid <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      if (req_data[gidx].cpu_msg == CPU_READ_ATOM) begin
        lock_valid <= 1'b1;
        lock_id <= gidx;
      end else if (req_data[gidx].cpu_msg == CPU_WRITE_ATOM) begin
        lock_valid <= 1'b0;
      end
    end
  end
`else
  assign locked_out = '0;
`endif
endmodule
